// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main controller.
// Holds the state enum, opcode constants and datapath mux/ALU encodings.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      R_EX     = 4'd6,
      R_WB     = 4'd7,
      BEQ      = 4'd8,
      JMP      = 4'd9,
      ADDI_EX  = 4'd10,
      ADDI_WB  = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_FUNCT = 2'd2;
   localparam logic [1:0] ALU_ADDI  = 2'd3;

   localparam logic [1:0] SRCB_B      = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   // Raw per-state control word; FETCH strobes are qualified by mem_ready in the top.
   typedef struct packed {
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_word_t;

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational decoder from controller state to the Moore datapath control word.
module ctrl_out_decode
   import mips_ctrl_pkg::*;
(
   input  state_t     i_state,
   output ctrl_word_t o_ctrl
);

   always_comb begin
      o_ctrl = '0;
      case (i_state)
         FETCH: begin
            o_ctrl.mem_read  = 1'b1;
            o_ctrl.ir_write  = 1'b1;
            o_ctrl.pc_write  = 1'b1;
            o_ctrl.alu_src_b = SRCB_FOUR;
            o_ctrl.alu_op    = ALU_ADD;
            o_ctrl.pc_source = PCSRC_ALU;
         end
         DECODE: begin
            o_ctrl.alu_src_b = SRCB_IMM_SH;
            o_ctrl.alu_op    = ALU_ADD;
         end
         MEM_ADDR: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_IMM;
            o_ctrl.alu_op    = ALU_ADD;
         end
         MEM_RD: begin
            o_ctrl.mem_read = 1'b1;
            o_ctrl.i_or_d   = 1'b1;
         end
         MEM_WB: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.mem_to_reg = 1'b1;
         end
         MEM_WR: begin
            o_ctrl.mem_write = 1'b1;
            o_ctrl.i_or_d    = 1'b1;
         end
         R_EX: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_B;
            o_ctrl.alu_op    = ALU_FUNCT;
         end
         R_WB: begin
            o_ctrl.reg_write = 1'b1;
            o_ctrl.reg_dst   = 1'b1;
         end
         BEQ: begin
            o_ctrl.alu_src_a     = 1'b1;
            o_ctrl.alu_src_b     = SRCB_B;
            o_ctrl.alu_op        = ALU_SUB;
            o_ctrl.pc_write_cond = 1'b1;
            o_ctrl.pc_source     = PCSRC_ALUOUT;
         end
         JMP: begin
            o_ctrl.pc_write  = 1'b1;
            o_ctrl.pc_source = PCSRC_JUMP;
         end
         ADDI_EX: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_IMM;
            o_ctrl.alu_op    = ALU_ADDI;
         end
         ADDI_WB: begin
            o_ctrl.reg_write = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main FSM of the multi-cycle MIPS core: sequences fetch/decode/execute/memory/
// write-back, stalls on mem_ready and counts retired instructions.
module multicycle_ctrl
   import mips_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic        i_or_d,
   output logic        mem_read,
   output logic        mem_write,
   output logic        mem_to_reg,
   output logic        reg_dst,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [1:0]  pc_source,
   output logic        illegal,
   output logic [31:0] retired,
   output logic [3:0]  state
);

   state_t     r_state;
   state_t     w_next;
   logic       w_retire;
   logic       w_illegal;
   logic       w_fetch_ok;
   logic       w_unused_inputs;
   logic [31:0] r_retired;
   ctrl_word_t w_ctrl;

   // funct goes to the ALU decoder and zero to the PC-write logic; neither steers this FSM.
   assign w_unused_inputs = ^{funct, zero};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= FETCH;
         r_retired <= '0;
      end else begin
         r_state   <= w_next;
         r_retired <= r_retired + {31'd0, w_retire};
      end
   end

   always_comb begin
      w_next    = r_state;
      w_retire  = 1'b0;
      w_illegal = 1'b0;
      case (r_state)
         FETCH:    if (mem_ready) w_next = DECODE;
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW: w_next = MEM_ADDR;
               OP_RTYPE:     w_next = R_EX;
               OP_BEQ:       w_next = BEQ;
               OP_J:         w_next = JMP;
               OP_ADDI:      w_next = ADDI_EX;
               default: begin
                  w_next    = FETCH;
                  w_illegal = 1'b1;
               end
            endcase
         end
         MEM_ADDR: w_next = (opcode == OP_SW) ? MEM_WR : MEM_RD;
         MEM_RD:   if (mem_ready) w_next = MEM_WB;
         MEM_WR: begin
            if (mem_ready) begin
               w_next   = FETCH;
               w_retire = 1'b1;
            end
         end
         R_EX:     w_next = R_WB;
         ADDI_EX:  w_next = ADDI_WB;
         MEM_WB, R_WB, BEQ, JMP, ADDI_WB: begin
            w_next   = FETCH;
            w_retire = 1'b1;
         end
         default:  w_next = FETCH;
      endcase
   end

   ctrl_out_decode u_decode (
      .i_state (r_state),
      .o_ctrl  (w_ctrl)
   );

   // Fetch-time IR/PC writes only fire once memory has delivered the word.
   assign w_fetch_ok = (r_state != FETCH) || mem_ready;

   assign ir_write      = rst_n & w_ctrl.ir_write & w_fetch_ok;
   assign pc_write      = rst_n & w_ctrl.pc_write & w_fetch_ok;
   assign pc_write_cond = rst_n & w_ctrl.pc_write_cond;
   assign mem_read      = rst_n & w_ctrl.mem_read;
   assign mem_write     = rst_n & w_ctrl.mem_write;
   assign reg_write     = rst_n & w_ctrl.reg_write;
   assign illegal       = rst_n & w_illegal;
   assign i_or_d        = w_ctrl.i_or_d;
   assign mem_to_reg    = w_ctrl.mem_to_reg;
   assign reg_dst       = w_ctrl.reg_dst;
   assign alu_src_a     = w_ctrl.alu_src_a;
   assign alu_src_b     = w_ctrl.alu_src_b;
   assign alu_op        = w_ctrl.alu_op;
   assign pc_source     = w_ctrl.pc_source;
   assign retired       = r_retired;
   assign state         = r_state;

endmodule
